mwpipe: RTL and testbench
=========================

MWPIPE -- requirements
Module: mwpipe

Interface
REQ-001 Parameter DATA_W, default 128, width of ALU-result and read-data paths.
REQ-002 Parameter RADDR_W, default 4, width of destination register index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall_W  input  1  1 = hold writeback-stage contents; 0 = load from memory stage.
REQ-006 regw_M  input  1  register-write enable from memory stage.
REQ-007 regmem_M  input  1  writeback-source select from memory stage (1 = memory data, 0 = ALU result).
REQ-008 regScr_M  input  RADDR_W  destination register index from memory stage.
REQ-009 ALUrslt_M  input  DATA_W  ALU/vector result from memory stage.
REQ-010 readdata_M  input  DATA_W  data memory read data from memory stage.
REQ-011 regw_W  output  1  registered regw_M.
REQ-012 regmem_W  output  1  registered regmem_M.
REQ-013 regScr_W  output  RADDR_W  registered regScr_M.
REQ-014 ALUrslt_W  output  DATA_W  registered ALUrslt_M.
REQ-015 readdata_W  output  DATA_W  registered readdata_M.

Function
REQ-016 Every output SHALL be driven directly from a flip-flop; no combinational path from any input to any output.
REQ-017 With rst=0 and stall_W=0, each *_W output SHALL equal its *_M input as sampled at the preceding rising clk edge (latency 1 cycle).
REQ-018 With rst=0 and stall_W=1 at a rising edge, all *_W outputs SHALL keep their previous values, all fields together.
REQ-019 Stall SHALL apply to all five fields as one unit; no field updates while others hold.
REQ-020 Data fields SHALL be passed bit-exact with no sign extension, truncation or manipulation.
REQ-021 Outputs SHALL NOT change between clock edges except on rst assertion.
REQ-022 Stall asserted for N consecutive edges SHALL hold contents for N cycles; first edge with stall_W=0 loads the then-current inputs.

Reset
REQ-023 rst=1 SHALL immediately, without a clock edge, force regw_W=0, regmem_W=0, regScr_W=0, ALUrslt_W=0, readdata_W=0.
REQ-024 rst SHALL take priority over stall_W and over all data inputs while asserted.
REQ-025 After rst deasserts, the first rising edge SHALL follow REQ-017/REQ-018; reset mid-operation SHALL discard held or in-flight contents.
REQ-026 Reset state SHALL be a bubble: regw_W=0 means no register-file write.

Structure
REQ-027 A shared pipeline package SHALL hold DATA_W and RADDR_W defaults (128, 4) for reuse by all pipeline registers of the processor.
REQ-028 One sub-module pipe_reg SHALL be used: a parameterized-width register with async active-high reset to zero and an active-high hold enable. mwpipe instantiates one pipe_reg per field, or one over the concatenated fields.

Verification
REQ-029 Clock 20 ns period. rst=1 for 55 ns with all inputs 0 -> all outputs 0; no outputs change on edges during reset.
REQ-030 rst=0, stall_W=0, apply regw_M=1, regmem_M=0, regScr_M=4'b0011, ALUrslt_M=128'h0000FFFF -> these values appear on *_W after the next rising edge, not before.
REQ-031 Next cycle, regScr_M=4'b0100 with the same other fields -> regScr_W=4'b0100 one edge later; ALUrslt_W stays 128'h0000FFFF.
REQ-032 Load regScr_M=4'b0011, then stall_W=1 for 3 cycles while changing regScr_M=4'b0100 and readdata_M=128'hDEAD -> outputs hold 4'b0011 and the old readdata; the first edge after stall_W=0 loads 4'b0100 and 128'hDEAD.
REQ-033 Load all-ones data and regw_M=1, then pulse rst mid-cycle between edges -> all outputs 0 immediately, without waiting for an edge.
REQ-034 stall_W=1 and rst=1 together -> outputs 0; after rst release with stall_W=1, outputs stay 0 until stall_W=0.

Source files
------------

// File: rtl/mwpipe_pkg.sv
// Shared pipeline definitions for the processor's inter-stage registers.
// Holds the default data-path and register-index widths so every pipeline
// register agrees on them, plus a helper that sizes the memory->writeback
// bundle (regw, regmem, dest index, ALU result, read data).
package mwpipe_pkg;

  localparam int PIPE_DATA_W  = 128;
  localparam int PIPE_RADDR_W = 4;

  // Two control bits + destination index + two data words.
  function automatic int mw_bundle_w(input int data_w, input int raddr_w);
    return 2 + raddr_w + 2 * data_w;
  endfunction

endpackage

// File: rtl/mwpipe_pipe_reg.sv
// pipe_reg: generic pipeline register.
//   clk  - rising-edge clock
//   rst  - async active-high reset, clears q to zero
//   hold - 1 = keep q, 0 = load d
//   d    - next-stage data in (W bits)
//   q    - registered data out (W bits)
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (!hold) q <= d;
  end

endmodule

// File: rtl/mwpipe.sv
// mwpipe: memory -> writeback pipeline register.
//   clk, rst          - clock, async active-high reset (reset = bubble, all 0)
//   stall_W           - 1 = hold writeback contents, 0 = load memory stage
//   regw_M/regmem_M   - register-write enable / writeback source select
//   regScr_M          - destination register index (RADDR_W)
//   ALUrslt_M         - ALU/vector result (DATA_W)
//   readdata_M        - data memory read data (DATA_W)
//   *_W               - the same fields, registered
// All fields share one register so a stall can never split them.
module mwpipe
  import mwpipe_pkg::*;
#(
  parameter int DATA_W  = PIPE_DATA_W,
  parameter int RADDR_W = PIPE_RADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_W,
  input  logic               regw_M,
  input  logic               regmem_M,
  input  logic [RADDR_W-1:0] regScr_M,
  input  logic [DATA_W-1:0]  ALUrslt_M,
  input  logic [DATA_W-1:0]  readdata_M,
  output logic               regw_W,
  output logic               regmem_W,
  output logic [RADDR_W-1:0] regScr_W,
  output logic [DATA_W-1:0]  ALUrslt_W,
  output logic [DATA_W-1:0]  readdata_W
);

  localparam int BW = mw_bundle_w(DATA_W, RADDR_W);

  logic [BW-1:0] bundle_m;
  logic [BW-1:0] bundle_w;

  assign bundle_m = {regw_M, regmem_M, regScr_M, ALUrslt_M, readdata_M};

  pipe_reg #(.W(BW)) u_mw_reg (
    .clk  (clk),
    .rst  (rst),
    .hold (stall_W),
    .d    (bundle_m),
    .q    (bundle_w)
  );

  // Pure wiring: outputs come straight off the register bits.
  assign {regw_W, regmem_W, regScr_W, ALUrslt_W, readdata_W} = bundle_w;

endmodule

// File: tb/tb_mwpipe.sv
module tb_mwpipe;

  typedef struct packed {
    logic         regw;
    logic         regmem;
    logic [3:0]   scr;
    logic [127:0] alu;
    logic [127:0] rd;
  } wb_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stall_W = 1'b0;
  logic         regw_M = 1'b0, regmem_M = 1'b0;
  logic [3:0]   regScr_M = '0;
  logic [127:0] ALUrslt_M = '0, readdata_M = '0;
  logic         regw_W, regmem_W;
  logic [3:0]   regScr_W;
  logic [127:0] ALUrslt_W, readdata_W;

  int n_cmp = 0;
  int n_bad = 0;

  wb_t exp_q[$];
  wb_t model = '0;   // what the writeback stage should currently hold

  mwpipe #(.DATA_W(128), .RADDR_W(4)) dut (
    .clk(clk), .rst(rst), .stall_W(stall_W),
    .regw_M(regw_M), .regmem_M(regmem_M), .regScr_M(regScr_M),
    .ALUrslt_M(ALUrslt_M), .readdata_M(readdata_M),
    .regw_W(regw_W), .regmem_W(regmem_W), .regScr_W(regScr_W),
    .ALUrslt_W(ALUrslt_W), .readdata_W(readdata_W)
  );

  always #10 clk = ~clk;

  function automatic wb_t outs();
    wb_t o;
    o = '{regw: regw_W, regmem: regmem_W, scr: regScr_W, alu: ALUrslt_W, rd: readdata_W};
    return o;
  endfunction

  task automatic check(input string name, input wb_t want);
    wb_t got;
    got = outs();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // One memory-stage cycle: drive on the falling edge, optionally pulse reset
  // between edges first, and queue what the next rising edge must produce.
  task automatic cycle(input logic r, input logic st, input wb_t v, input logic mid_rst);
    @(negedge clk);
    if (mid_rst) begin
      rst = 1'b1;
      #1 check("async_rst", '0);
      model = '0;
      #1 rst = 1'b0;
    end
    rst = r; stall_W = st;
    {regw_M, regmem_M, regScr_M, ALUrslt_M, readdata_M} = v;
    #1 check("no_comb_path", r ? wb_t'('0) : model);
    if (r)       model = '0;
    else if (!st) model = v;
    exp_q.push_back(model);
  endtask

  // Monitor: after every rising edge that has an expectation queued.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("wb_out", exp_q.pop_front());
    end
  end

  function automatic wb_t rnd();
    wb_t v;
    v.regw = 1'($urandom); v.regmem = 1'($urandom); v.scr = 4'($urandom);
    v.alu = {$urandom, $urandom, $urandom, $urandom};
    v.rd  = {$urandom, $urandom, $urandom, $urandom};
    return v;
  endfunction

  initial begin
    wb_t a, b, ones;
    int  w;
    ones = '1;
    // Reset held for 55 ns with inputs at zero.
    #1 check("reset_imm", '0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    @(posedge clk); #5 rst = 1'b0;

    // Basic load, then destination change only.
    a = '{regw: 1'b1, regmem: 1'b0, scr: 4'b0011, alu: 128'h0000FFFF, rd: '0};
    cycle(1'b0, 1'b0, a, 1'b0);
    a.scr = 4'b0100;
    cycle(1'b0, 1'b0, a, 1'b0);

    // Stall for three edges while the inputs change.
    a = '{regw: 1'b1, regmem: 1'b1, scr: 4'b0011, alu: 128'h1234, rd: 128'hBEEF};
    cycle(1'b0, 1'b0, a, 1'b0);
    b = a; b.scr = 4'b0100; b.rd = 128'hDEAD;
    repeat (3) cycle(1'b0, 1'b1, b, 1'b0);
    cycle(1'b0, 1'b0, b, 1'b0);

    // All-ones load, then a reset pulse between edges.
    cycle(1'b0, 1'b0, ones, 1'b0);
    cycle(1'b0, 1'b1, ones, 1'b1);

    // Reset and stall together, then stall alone keeps the bubble.
    cycle(1'b0, 1'b0, ones, 1'b0);
    cycle(1'b1, 1'b1, ones, 1'b0);
    cycle(1'b0, 1'b1, ones, 1'b0);
    cycle(1'b0, 1'b1, ones, 1'b0);
    cycle(1'b0, 1'b0, ones, 1'b0);

    // Randomized traffic with stalls and occasional reset pulses.
    for (int i = 0; i < 300; i++)
      cycle(1'b0, ($urandom_range(0, 99) < 30), rnd(), ($urandom_range(0, 99) < 3));

    w = 0;
    while (exp_q.size() > 0 && w < 5) begin
      @(posedge clk); #2; w++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
